// File: rtl/vfpu_norm_round_if.sv
`default_nettype none
// ============================================================================
// Module   : vfpu_norm_round_if
// Brief    : Operand/result handshake bundle for the normalise-and-round stage.
//            The master side drives operands and consumes results; the slave
//            side is the datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface vfpu_norm_round_if #(
  parameter int EXP_W      = 8,
  parameter int MANT_W     = 23,
  parameter int PRE_MANT_W = 48,
  parameter int PRE_EXP_W  = 10
);
  logic                  clear_i;
  logic [1:0]            rnd_mode_i;
  logic                  valid_i;
  logic                  ready_o;
  logic                  sign_i;
  logic [PRE_EXP_W-1:0]  exponent_i;
  logic [PRE_MANT_W-1:0] mantissa_i;
  logic                  valid_o;
  logic                  ready_i;
  logic                  sign_o;
  logic [EXP_W-1:0]      exponent_o;
  logic [MANT_W:0]       mantissa_o;
  logic                  ovf_o;
  logic                  unf_o;
  logic                  inexact_o;
  logic                  done_o;

  modport master (
    output clear_i, rnd_mode_i, valid_i, sign_i, exponent_i, mantissa_i, ready_i,
    input  ready_o, valid_o, sign_o, exponent_o, mantissa_o, ovf_o, unf_o,
           inexact_o, done_o
  );

  modport slave (
    input  clear_i, rnd_mode_i, valid_i, sign_i, exponent_i, mantissa_i, ready_i,
    output ready_o, valid_o, sign_o, exponent_o, mantissa_o, ovf_o, unf_o,
           inexact_o, done_o
  );
endinterface
`default_nettype wire

// File: rtl/vfpu_norm_round.sv
`default_nettype none
// ============================================================================
// Module   : vfpu_norm_round
// Brief    : Two-stage normalise (S1) and round/saturate (S2) pipeline for a
//            floating-point result. Valid/ready on both sides, synchronous
//            flush, registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
module vfpu_norm_round #(
  parameter int EXP_W      = 8,
  parameter int MANT_W     = 23,
  parameter int PRE_MANT_W = 48,
  parameter int PRE_EXP_W  = 10
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  vfpu_norm_round_if.slave    bus
);

  // Internal exponent carries two spare bits so +1 and -(lzc-1) never wrap.
  localparam int NE  = PRE_EXP_W + 2;
  localparam int LZW = $clog2(PRE_MANT_W + 1);
  localparam int FW  = MANT_W + 1;

  localparam logic [NE-1:0]    EXP_OVF     = NE'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0] EXP_INF     = '1;
  localparam logic [EXP_W-1:0] EXP_MAX_FIN = {{(EXP_W-1){1'b1}}, 1'b0};

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RUP = 2'd2;
  localparam logic [1:0] RM_RDN = 2'd3;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic s1_valid;
  logic s2_valid;
  logic s2_load;
  logic s1_load;
  logic accept;
  logic s1_move;

  assign s2_load     = ~s2_valid | bus.ready_i;
  assign s1_load     = ~s1_valid | s2_load;
  assign accept      = bus.valid_i & s1_load;
  assign s1_move     = s1_valid & s2_load;
  assign bus.ready_o = s1_load;

  // --------------------------------------------------------------------------
  // S1 combinational normaliser
  // --------------------------------------------------------------------------
  logic [LZW-1:0]        lzc;
  logic [PRE_MANT_W-2:0] norm;
  logic                  shift_out;
  logic [NE-1:0]         exp_ext;
  logic [NE-1:0]         exp_norm;
  logic                  in_zero;
  logic                  in_flush;

  // Leading-one detect, then align the leading one to the weight-1 position.
  always_comb begin
    lzc = LZW'(PRE_MANT_W);
    for (int i = 0; i < PRE_MANT_W; i++) begin
      if (bus.mantissa_i[i]) lzc = LZW'(PRE_MANT_W - 1 - i);
    end
    exp_ext = {{(NE-PRE_EXP_W){bus.exponent_i[PRE_EXP_W-1]}}, bus.exponent_i};
    if (bus.mantissa_i[PRE_MANT_W-1]) begin
      norm      = bus.mantissa_i[PRE_MANT_W-1:1];
      shift_out = bus.mantissa_i[0];
      exp_norm  = exp_ext + NE'(1);
    end else begin
      // Top bit is known zero after the shift, so dropping it loses nothing.
      norm      = (PRE_MANT_W-1)'(bus.mantissa_i << (lzc - LZW'(1)));
      shift_out = 1'b0;
      exp_norm  = exp_ext + NE'(1) - NE'(lzc);
    end
    in_zero  = ~|bus.mantissa_i;
    in_flush = ~in_zero & (exp_norm[NE-1] | ~|exp_norm);
  end

  // --------------------------------------------------------------------------
  // S1 registers
  // --------------------------------------------------------------------------
  logic           s1_sign;
  logic [1:0]     s1_rnd;
  logic           s1_zero;
  logic           s1_flush;
  logic [NE-1:0]  s1_exp;
  logic [FW-1:0]  s1_mant;
  logic           s1_g;
  logic           s1_s;

  // Capture the normalised operand; flush beats any load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_rnd   <= RM_RNE;
      s1_zero  <= 1'b0;
      s1_flush <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_g     <= 1'b0;
      s1_s     <= 1'b0;
    end else if (bus.clear_i) begin
      s1_valid <= 1'b0;
    end else begin
      if (s1_load) s1_valid <= bus.valid_i;
      if (accept) begin
        s1_sign  <= bus.sign_i;
        s1_rnd   <= bus.rnd_mode_i;
        s1_zero  <= in_zero;
        s1_flush <= in_flush;
        s1_exp   <= exp_norm;
        s1_mant  <= norm[PRE_MANT_W-2 -: FW];
        s1_g     <= norm[PRE_MANT_W-3-MANT_W];
        s1_s     <= (|norm[PRE_MANT_W-4-MANT_W:0]) | shift_out;
      end
    end
  end

  // --------------------------------------------------------------------------
  // S2 combinational rounding and saturation
  // --------------------------------------------------------------------------
  logic             inc;
  logic [FW:0]      sum;
  logic             carry;
  logic [FW-1:0]    rmant;
  logic [NE-1:0]    rexp;
  logic             to_inf;
  logic [EXP_W-1:0] n_exp;
  logic [FW-1:0]    n_mant;
  logic             n_ovf;
  logic             n_unf;
  logic             n_inx;

  // Round increment, carry renormalisation, then zero/flush/overflow select.
  always_comb begin
    unique case (s1_rnd)
      RM_RNE:  inc = s1_g & (s1_s | s1_mant[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~s1_sign & (s1_g | s1_s);
      default: inc = s1_sign & (s1_g | s1_s);
    endcase
    sum    = {1'b0, s1_mant} + {{FW{1'b0}}, inc};
    carry  = sum[FW];
    rmant  = carry ? {1'b1, {MANT_W{1'b0}}} : sum[FW-1:0];
    rexp   = s1_exp + {{(NE-1){1'b0}}, carry};
    to_inf = (s1_rnd == RM_RNE) | ((s1_rnd == RM_RUP) & ~s1_sign) |
             ((s1_rnd == RM_RDN) & s1_sign);

    n_exp  = rexp[EXP_W-1:0];
    n_mant = rmant;
    n_ovf  = 1'b0;
    n_unf  = 1'b0;
    n_inx  = s1_g | s1_s;
    if (s1_zero) begin
      n_exp  = '0;
      n_mant = '0;
      n_inx  = 1'b0;
    end else if (s1_flush) begin
      n_exp  = '0;
      n_mant = '0;
      n_unf  = 1'b1;
      n_inx  = 1'b1;
    end else if (rexp >= EXP_OVF) begin
      n_ovf  = 1'b1;
      n_inx  = 1'b1;
      n_exp  = to_inf ? EXP_INF : EXP_MAX_FIN;
      n_mant = to_inf ? '0 : '1;
    end
  end

  // --------------------------------------------------------------------------
  // S2 registers (drive outputs directly)
  // --------------------------------------------------------------------------
  logic             out_sign;
  logic [EXP_W-1:0] out_exp;
  logic [FW-1:0]    out_mant;
  logic             out_ovf;
  logic             out_unf;
  logic             out_inx;

  // Result register; holds while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid <= 1'b0;
      out_sign <= 1'b0;
      out_exp  <= '0;
      out_mant <= '0;
      out_ovf  <= 1'b0;
      out_unf  <= 1'b0;
      out_inx  <= 1'b0;
    end else if (bus.clear_i) begin
      s2_valid <= 1'b0;
    end else begin
      if (s2_load) s2_valid <= s1_valid;
      if (s1_move) begin
        out_sign <= s1_sign;
        out_exp  <= n_exp;
        out_mant <= n_mant;
        out_ovf  <= n_ovf;
        out_unf  <= n_unf;
        out_inx  <= n_inx;
      end
    end
  end

  assign bus.valid_o    = s2_valid;
  assign bus.done_o     = s2_valid & bus.ready_i;
  assign bus.sign_o     = out_sign;
  assign bus.exponent_o = out_exp;
  assign bus.mantissa_o = out_mant;
  assign bus.ovf_o      = out_ovf;
  assign bus.unf_o      = out_unf;
  assign bus.inexact_o  = out_inx;

endmodule
`default_nettype wire
